// File: rtl/seg7_scan_reader.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: recovers the hex nibble of
// each scanned digit and delivers a complete frame with a valid/ready handshake.
module seg7_scan_reader #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_t;

    logic [SYNC_STAGES-1:0][6:0]            seg_sync;
    logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] en_sync;
    logic [6:0]                             s_seg;
    logic [NUM_DIGITS-1:0]                  s_en;

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [6:0]            pat_q, pat_d;
    logic                  wr, restart, one_hot, changed, complete;
    logic [4:0]            dec;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [NUM_DIGITS-1:0]   seen_q;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h10;  // err flag, nibble forced to 0
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sync <= '0;
            en_sync  <= '0;
        end else begin
            seg_sync <= {seg_sync[SYNC_STAGES-2:0], seg_in};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], dig_en};
        end
    end

    assign s_seg    = seg_sync[SYNC_STAGES-1];
    assign s_en     = en_sync[SYNC_STAGES-1];
    assign one_hot  = (s_en != '0) &&
                      ((s_en & (s_en - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);
    assign changed  = (s_en != en_q) || (s_seg != pat_q);
    assign dec      = decode(s_seg);
    assign complete = &seen_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        pat_d   = pat_q;
        wr      = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (one_hot) restart = 1'b1;
            end
            StSettle, StHeld: begin
                if (!one_hot) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (changed) begin
                    restart = 1'b1;
                end else if (state_q == StSettle) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q + CntW'(1) == CntW'(STABLE_CYCLES)) begin
                        wr      = 1'b1;
                        state_d = StHeld;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (restart) begin
            en_d  = s_en;
            pat_d = s_seg;
            cnt_d = CntW'(1);
            if (STABLE_CYCLES == 1) begin
                wr      = 1'b1;
                state_d = StHeld;
            end else begin
                state_d = StSettle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            en_q    <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            pat_q   <= pat_d;
        end
    end

    // A capture landing in the completion cycle starts the next frame's seen mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_err <= '0;
            seen_q     <= '0;
        end else begin
            seen_q <= (complete ? '0 : seen_q) | (wr ? s_en : '0);
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                if (wr && s_en[k]) begin
                    shadow_val[4*k +: 4] <= dec[3:0];
                    shadow_err[k]        <= dec[4];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_value <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (complete) begin
            if (!frame_valid || frame_ready) begin
                frame_value <= shadow_val;
                frame_err   <= shadow_err;
                frame_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: expected frames are queued as scans are driven
// and compared when the DUT raises frame_valid.
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [5:0]  dig_en;
    logic [23:0] frame_value;
    logic [5:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    typedef struct {
        logic [23:0] val;
        logic [5:0]  err;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     lat;

    seg7_scan_reader #(
        .NUM_DIGITS   (6),
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_en     (dig_en),
        .frame_value(frame_value),
        .frame_err  (frame_err),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input logic [5:0] e, input int n);
        @(negedge clk);
        seg_in = p;
        dig_en = e;
        repeat (n) @(posedge clk);
    endtask

    // pats holds digit k's pattern at [7k+6:7k]
    task automatic scan(input logic [41:0] pats, input int n);
        for (int k = 0; k < 6; k++) hold(pats[7*k +: 7], 6'(1 << k), n);
        hold(7'h7F, 6'h00, 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        seg_in = 7'h7F;
        dig_en = 6'h00;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [23:0] v, input logic [5:0] e);
        frame_t f;
        f.val = v;
        f.err = e;
        exp_q.push_back(f);
    endtask

    task automatic wait_frame(input string tag);
        frame_t f;
        int     n = 0;
        @(negedge clk);
        while (!frame_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(frame_valid), 1);
        chk({tag, "_queued"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            chk({tag, "_value"}, 32'(frame_value), 32'(f.val));
            chk({tag, "_err"}, 32'(frame_err), 32'(f.err));
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop"}, 32'(frame_valid), 0);
        frame_ready = 1'b0;
    endtask

    localparam logic [41:0] PatsA   = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [41:0] PatsErr = {7'h02, 7'h12, 7'h7F, 7'h30, 7'h24, 7'h79};
    localparam logic [41:0] PatsB   = {7'h78, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [41:0] Pats8   = {6{7'h00}};

    initial begin
        rst = 1'b1;
        seg_in = 7'h7F;
        dig_en = 6'h00;
        frame_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_value", 32'(frame_value), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Basic scan with latency measurement on the final digit
        push(24'h654321, 6'b000000);
        for (int k = 0; k < 5; k++) hold(PatsA[7*k +: 7], 6'(1 << k), 8);
        @(negedge clk);
        seg_in = 7'h02;
        dig_en = 6'b100000;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_valid) begin
                lat = i;
                break;
            end
        end
        chk("t1_latency", 32'(lat), 7);
        wait_frame("t1");
        chk("t1_overrun", 32'(overrun), 0);
        hold(7'h7F, 6'h00, 4);
        accept("t1");

        // Non-hex pattern on digit 3
        push(24'h650321, 6'b001000);
        scan(PatsErr, 8);
        wait_frame("t2");
        accept("t2");

        // Digits held one cycle short of the stability window
        scan(PatsA, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_no_valid", 32'(frame_valid), 0);

        // Back-to-back frames without acceptance
        push(24'h654321, 6'b000000);
        scan(PatsA, 8);
        wait_frame("t4a");
        scan(PatsB, 8);
        @(negedge clk);
        chk("t4_held_valid", 32'(frame_valid), 1);
        chk("t4_held_value", 32'(frame_value), 32'h654321);
        chk("t4_overrun", 32'(overrun), 1);
        accept("t4");
        chk("t4_overrun_sticky", 32'(overrun), 1);

        // Multi-hot strobe ignored
        do_reset();
        chk("t5_overrun_clr", 32'(overrun), 0);
        hold(7'h79, 6'b000011, 10);
        @(negedge clk);
        chk("t5_no_valid", 32'(frame_valid), 0);
        push(24'h654321, 6'b000000);
        scan(PatsA, 8);
        wait_frame("t5");
        accept("t5");

        // Reset mid-frame discards partial capture
        for (int k = 0; k < 3; k++) hold(PatsA[7*k +: 7], 6'(1 << k), 8);
        do_reset();
        chk("t6_after_rst", 32'(frame_valid), 0);
        for (int k = 0; k < 5; k++) hold(7'h00, 6'(1 << k), 8);
        @(negedge clk);
        chk("t6_partial", 32'(frame_valid), 0);
        push(24'h888888, 6'b000000);
        hold(7'h00, 6'b100000, 8);
        hold(7'h7F, 6'h00, 4);
        wait_frame("t6");
        accept("t6");

        // Re-captured digit: last value wins
        push(24'h654322, 6'b000000);
        hold(7'h79, 6'b000001, 8);
        scan({PatsA[41:7], 7'h24}, 8);
        wait_frame("t7");
        accept("t7");
        chk("t7_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
